// File: rtl/sccb_slave_regfile.sv
// SCCB slave with an 8-bit register file: oversampled bus decode, ID/sub-address/data phases,
// open-drain ACK and read-data drive.
module sccb_slave_regfile #(
  parameter logic [6:0] SLV_DVC_ADDR = 7'h21,
  parameter int         REG_NUM      = 16,
  parameter int         DATA_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sio_c,
  inout  wire                       sio_d,
  output logic                      reg_wr_en_o,
  output logic [7:0]                reg_wr_addr_o,
  output logic [DATA_W-1:0]         reg_wr_data_o,
  output logic [REG_NUM*DATA_W-1:0] regs_o,
  output logic                      busy_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_ID_ACK,
    S_SUBADR,
    S_SUBADR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_NA,
    S_IGNORE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          cSync_q, dSync_q;
  logic                cPrev_q, dPrev_q;
  logic [3:0]          bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rdShift_q, rdShift_d;
  logic [7:0]          ptr_q, ptr_d;
  logic                isRead_q, isRead_d;
  logic                driveLow_q, driveLow_d;
  logic                busy_q, busy_d;
  logic                wrEn_q, wrEn_d;
  logic [7:0]          wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0]   wrData_q, wrData_d;
  logic [DATA_W-1:0]   regs_q [REG_NUM];
  logic [DATA_W-1:0]   rdByte;
  logic                cS, dS, startDet, stopDet, sclRise, sclFall, inRange;

  assign sio_d = driveLow_q ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-high bus level so leaving reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cSync_q <= 2'b11;
      dSync_q <= 2'b11;
      cPrev_q <= 1'b1;
      dPrev_q <= 1'b1;
    end else begin
      cSync_q <= {cSync_q[0], sio_c};
      dSync_q <= {dSync_q[0], sio_d};
      cPrev_q <= cSync_q[1];
      dPrev_q <= dSync_q[1];
    end
  end

  assign cS       = cSync_q[1];
  assign dS       = dSync_q[1];
  assign startDet = cS & cPrev_q & dPrev_q & ~dS;
  assign stopDet  = cS & cPrev_q & ~dPrev_q & dS;
  assign sclRise  = cS & ~cPrev_q;
  assign sclFall  = ~cS & cPrev_q;
  assign inRange  = ({1'b0, ptr_q} < 9'(REG_NUM));

  always_comb begin
    rdByte = '0;
    for (int k = 0; k < REG_NUM; k++) begin
      if (ptr_q == 8'(k)) rdByte = regs_q[k];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < REG_NUM; k++) begin
      regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      rdShift_q  <= '0;
      ptr_q      <= '0;
      isRead_q   <= 1'b0;
      driveLow_q <= 1'b0;
      busy_q     <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      rdShift_q  <= rdShift_d;
      ptr_q      <= ptr_d;
      isRead_q   <= isRead_d;
      driveLow_q <= driveLow_d;
      busy_q     <= busy_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
    end
  end

  // Register file changes on the same edge that raises reg_wr_en_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < REG_NUM; k++) regs_q[k] <= '0;
    end else if (wrEn_d) begin
      for (int k = 0; k < REG_NUM; k++) begin
        if (ptr_q == 8'(k)) regs_q[k] <= wrData_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    rdShift_d  = rdShift_q;
    ptr_d      = ptr_q;
    isRead_d   = isRead_q;
    driveLow_d = driveLow_q;
    busy_d     = busy_q;
    wrEn_d     = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    if (startDet) begin
      state_d    = S_ID;
      bitCnt_d   = '0;
      driveLow_d = 1'b0;
      busy_d     = 1'b1;
    end else if (stopDet) begin
      state_d    = S_IDLE;
      bitCnt_d   = '0;
      driveLow_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        S_ID, S_SUBADR, S_WDATA: begin
          if (sclRise) begin
            shift_d  = {shift_q[DATA_W-2:0], dS};
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d = '0;
              if (state_q == S_ID) begin
                if (shift_d[DATA_W-1:1] == SLV_DVC_ADDR) begin
                  state_d  = S_ID_ACK;
                  isRead_d = shift_d[0];
                end else begin
                  state_d = S_IGNORE;
                end
              end else if (state_q == S_SUBADR) begin
                ptr_d   = shift_d[7:0];
                state_d = S_SUBADR_ACK;
              end else begin
                if (inRange) begin
                  wrEn_d   = 1'b1;
                  wrAddr_d = ptr_q;
                  wrData_d = shift_d;
                end
                state_d = S_WDATA_ACK;
              end
            end
          end
        end
        // bitCnt_q marks whether the 9th (ACK) rising edge has been seen yet.
        S_ID_ACK, S_SUBADR_ACK, S_WDATA_ACK: begin
          if (sclRise) begin
            bitCnt_d = 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd0) begin
              driveLow_d = 1'b1;
            end else begin
              driveLow_d = 1'b0;
              bitCnt_d   = '0;
              if (state_q == S_ID_ACK && isRead_q) begin
                state_d    = S_RDATA;
                rdShift_d  = rdByte;
                driveLow_d = ~rdByte[DATA_W-1];
              end else if (state_q == S_ID_ACK) begin
                state_d = S_SUBADR;
              end else if (state_q == S_SUBADR_ACK) begin
                state_d = S_WDATA;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_RDATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              driveLow_d = 1'b0;
              bitCnt_d   = '0;
              state_d    = S_RDATA_NA;
            end else begin
              rdShift_d  = {rdShift_q[DATA_W-2:0], 1'b0};
              driveLow_d = ~rdShift_q[DATA_W-2];
            end
          end
        end
        S_RDATA_NA: begin
          if (sclRise) state_d = S_IGNORE;
        end
        S_IDLE, S_IGNORE: driveLow_d = 1'b0;
        default: begin
          state_d    = S_IDLE;
          driveLow_d = 1'b0;
        end
      endcase
    end
  end

  assign reg_wr_en_o   = wrEn_q;
  assign reg_wr_addr_o = wrAddr_q;
  assign reg_wr_data_o = wrData_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench for sccb_slave_regfile: a bit-banged SCCB master with hand-computed expectations.
module tb_sccb_slave_regfile;

  localparam int  REG_NUM = 16;
  localparam time Q       = 80ns;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 scl = 1'b1;
  logic                 mSdaLow = 1'b0;
  wire                  sio_d;
  logic                 reg_wr_en_o;
  logic [7:0]           reg_wr_addr_o;
  logic [7:0]           reg_wr_data_o;
  logic [REG_NUM*8-1:0] regs_o;
  logic                 busy_o;

  int                   vecCnt = 0;
  int                   errCnt = 0;
  int                   pulseCnt = 0;
  int                   highCycles = 0;
  logic                 prevEn = 1'b0;
  logic [7:0]           lastAddr = 8'h00;
  logic [7:0]           lastData = 8'h00;
  logic [REG_NUM*8-1:0] expRegs = '0;

  pullup (sio_d);
  assign sio_d = mSdaLow ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  sccb_slave_regfile #(.SLV_DVC_ADDR(7'h21), .REG_NUM(REG_NUM), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sio_c(scl), .sio_d(sio_d),
    .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o), .reg_wr_data_o(reg_wr_data_o),
    .regs_o(regs_o), .busy_o(busy_o)
  );

  // Write-pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reg_wr_en_o) begin
      highCycles++;
      if (!prevEn) begin
        pulseCnt++;
        lastAddr = reg_wr_addr_o;
        lastData = reg_wr_data_o;
      end
    end
    prevEn = reg_wr_en_o;
  end

  task automatic busStart();
    mSdaLow = 1'b0; #Q;
    scl = 1'b1;     #Q;
    mSdaLow = 1'b1; #Q;
    scl = 1'b0;     #Q;
  endtask

  task automatic busStop();
    mSdaLow = 1'b1; #Q;
    scl = 1'b1;     #Q;
    mSdaLow = 1'b0; #Q;
  endtask

  task automatic sendBit(input logic b);
    mSdaLow = ~b; #Q;
    scl = 1'b1;   #(2*Q);
    scl = 1'b0;   #Q;
  endtask

  task automatic readBit(output logic b);
    mSdaLow = 1'b0; #Q;
    scl = 1'b1;     #Q;
    b = sio_d;      #Q;
    scl = 1'b0;     #Q;
  endtask

  task automatic sendByte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(data[i]);
    readBit(ack);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] data, output logic naLevel);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      data[i] = b;
    end
    mSdaLow = ~nack; #Q;
    scl = 1'b1;      #Q;
    naLevel = sio_d; #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic test_reset();
    vecCnt++; if (regs_o !== '0) begin errCnt++; $display("[TB] FAIL reset_regs: got %h expected 0", regs_o); end
    vecCnt++; if (reg_wr_en_o !== 1'b0) begin errCnt++; $display("[TB] FAIL reset_wr_en: got %b expected 0", reg_wr_en_o); end
    vecCnt++; if (reg_wr_addr_o !== 8'h00) begin errCnt++; $display("[TB] FAIL reset_wr_addr: got %h expected 00", reg_wr_addr_o); end
    vecCnt++; if (reg_wr_data_o !== 8'h00) begin errCnt++; $display("[TB] FAIL reset_wr_data: got %h expected 00", reg_wr_data_o); end
    vecCnt++; if (busy_o !== 1'b0) begin errCnt++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    vecCnt++; if (sio_d !== 1'b1) begin errCnt++; $display("[TB] FAIL reset_sio_d: got %b expected released(1)", sio_d); end
  endtask

  task automatic test_write3();
    logic a0, a1, a2;
    int   p0;
    p0 = pulseCnt;
    busStart();
    sendByte(8'h42, a0);
    sendByte(8'h05, a1);
    sendByte(8'hA5, a2);
    vecCnt++; if ({a0, a1, a2} !== 3'b000) begin errCnt++; $display("[TB] FAIL w3_acks: got %b expected 000", {a0, a1, a2}); end
    vecCnt++; if (busy_o !== 1'b1) begin errCnt++; $display("[TB] FAIL w3_busy: got %b expected 1", busy_o); end
    busStop();
    expRegs[5*8 +: 8] = 8'hA5;
    vecCnt++; if (pulseCnt - p0 !== 1) begin errCnt++; $display("[TB] FAIL w3_pulses: got %0d expected 1", pulseCnt - p0); end
    vecCnt++; if (highCycles !== pulseCnt) begin errCnt++; $display("[TB] FAIL w3_pulse_width: got %0d high cycles expected %0d", highCycles, pulseCnt); end
    vecCnt++; if (lastAddr !== 8'h05) begin errCnt++; $display("[TB] FAIL w3_addr: got %h expected 05", lastAddr); end
    vecCnt++; if (lastData !== 8'hA5) begin errCnt++; $display("[TB] FAIL w3_data: got %h expected a5", lastData); end
    vecCnt++; if (regs_o[47:40] !== 8'hA5) begin errCnt++; $display("[TB] FAIL w3_reg5: got %h expected a5", regs_o[47:40]); end
    vecCnt++; if (busy_o !== 1'b0) begin errCnt++; $display("[TB] FAIL w3_busy_after_stop: got %b expected 0", busy_o); end
  endtask

  task automatic test_pointer_read();
    logic       a0, a1, a2, na;
    logic [7:0] d;
    int         p0;
    p0 = pulseCnt;
    busStart();
    sendByte(8'h42, a0);
    sendByte(8'h05, a1);
    busStop();
    busStart();
    sendByte(8'h43, a2);
    readByte(1'b1, d, na);
    busStop();
    vecCnt++; if ({a0, a1, a2} !== 3'b000) begin errCnt++; $display("[TB] FAIL pr_acks: got %b expected 000", {a0, a1, a2}); end
    vecCnt++; if (d !== 8'hA5) begin errCnt++; $display("[TB] FAIL pr_data: got %h expected a5", d); end
    vecCnt++; if (na !== 1'b1) begin errCnt++; $display("[TB] FAIL pr_na_released: got %b expected 1", na); end
    vecCnt++; if (pulseCnt !== p0) begin errCnt++; $display("[TB] FAIL pr_no_pulse: got %0d pulses expected 0", pulseCnt - p0); end
  endtask

  task automatic test_wrong_id();
    logic a0, a1, a2;
    int   p0;
    p0 = pulseCnt;
    busStart();
    sendByte(8'h60, a0);
    sendByte(8'h05, a1);
    sendByte(8'h11, a2);
    vecCnt++; if ({a0, a1, a2} !== 3'b111) begin errCnt++; $display("[TB] FAIL wid_no_ack: got %b expected 111", {a0, a1, a2}); end
    vecCnt++; if (busy_o !== 1'b1) begin errCnt++; $display("[TB] FAIL wid_busy: got %b expected 1", busy_o); end
    busStop();
    vecCnt++; if (busy_o !== 1'b0) begin errCnt++; $display("[TB] FAIL wid_busy_after_stop: got %b expected 0", busy_o); end
    vecCnt++; if (pulseCnt !== p0) begin errCnt++; $display("[TB] FAIL wid_no_pulse: got %0d pulses expected 0", pulseCnt - p0); end
    vecCnt++; if (regs_o !== expRegs) begin errCnt++; $display("[TB] FAIL wid_regs: got %h expected %h", regs_o, expRegs); end
  endtask

  task automatic test_out_of_range();
    logic       a0, a1, a2, a3, na;
    logic [7:0] d;
    int         p0;
    p0 = pulseCnt;
    busStart();
    sendByte(8'h42, a0);
    sendByte(8'h20, a1);
    sendByte(8'h77, a2);
    busStop();
    vecCnt++; if ({a0, a1, a2} !== 3'b000) begin errCnt++; $display("[TB] FAIL oor_acks: got %b expected 000", {a0, a1, a2}); end
    vecCnt++; if (pulseCnt !== p0) begin errCnt++; $display("[TB] FAIL oor_no_pulse: got %0d pulses expected 0", pulseCnt - p0); end
    vecCnt++; if (regs_o !== expRegs) begin errCnt++; $display("[TB] FAIL oor_regs: got %h expected %h", regs_o, expRegs); end
    busStart();
    sendByte(8'h43, a3);
    readByte(1'b1, d, na);
    busStop();
    vecCnt++; if (a3 !== 1'b0) begin errCnt++; $display("[TB] FAIL oor_read_ack: got %b expected 0", a3); end
    vecCnt++; if (d !== 8'h00) begin errCnt++; $display("[TB] FAIL oor_read_data: got %h expected 00", d); end
  endtask

  task automatic test_back_to_back();
    logic       a0, a1, a2, a3, b0, b1, b2, na;
    logic [7:0] d;
    int         p0;
    p0 = pulseCnt;
    busStart();
    sendByte(8'h42, a0);
    sendByte(8'h07, a1);
    sendByte(8'h3C, a2);
    sendByte(8'h99, a3);
    busStop();
    expRegs[7*8 +: 8] = 8'h3C;
    vecCnt++; if ({a0, a1, a2, a3} !== 4'b0001) begin errCnt++; $display("[TB] FAIL b2b_acks: got %b expected 0001", {a0, a1, a2, a3}); end
    vecCnt++; if (pulseCnt - p0 !== 1) begin errCnt++; $display("[TB] FAIL b2b_pulses: got %0d expected 1", pulseCnt - p0); end
    vecCnt++; if (regs_o !== expRegs) begin errCnt++; $display("[TB] FAIL b2b_regs: got %h expected %h", regs_o, expRegs); end
    busStart();
    sendByte(8'h42, b0);
    sendByte(8'h05, b1);
    busStart();
    sendByte(8'h43, b2);
    readByte(1'b1, d, na);
    busStop();
    vecCnt++; if ({b0, b1, b2} !== 3'b000) begin errCnt++; $display("[TB] FAIL rs_acks: got %b expected 000", {b0, b1, b2}); end
    vecCnt++; if (d !== 8'hA5) begin errCnt++; $display("[TB] FAIL rs_read_data: got %h expected a5", d); end
    vecCnt++; if (na !== 1'b1) begin errCnt++; $display("[TB] FAIL rs_na_released: got %b expected 1", na); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, bit7;
    int   p0;
    busStart();
    sendByte(8'h43, a0);
    readBit(bit7);
    #(Q/2);
    vecCnt++; if (bit7 !== 1'b1) begin errCnt++; $display("[TB] FAIL rmr_bit7: got %b expected 1", bit7); end
    vecCnt++; if (sio_d !== 1'b0) begin errCnt++; $display("[TB] FAIL rmr_driving_zero: got %b expected 0", sio_d); end
    rst_n = 1'b0;
    #1;
    vecCnt++; if (sio_d !== 1'b1) begin errCnt++; $display("[TB] FAIL rmr_released: got %b expected released(1)", sio_d); end
    vecCnt++; if (regs_o !== '0) begin errCnt++; $display("[TB] FAIL rmr_regs: got %h expected 0", regs_o); end
    vecCnt++; if ({busy_o, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o} !== 18'h0) begin
      errCnt++; $display("[TB] FAIL rmr_outputs: got %h expected 0", {busy_o, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o});
    end
    expRegs = '0;
    scl = 1'b1;
    #Q;
    rst_n = 1'b1;
    #(2*Q);
    p0 = pulseCnt;
    busStart();
    sendByte(8'h42, a0);
    sendByte(8'h01, a1);
    sendByte(8'h5A, a2);
    busStop();
    expRegs[1*8 +: 8] = 8'h5A;
    vecCnt++; if ({a0, a1, a2} !== 3'b000) begin errCnt++; $display("[TB] FAIL rmr_w_acks: got %b expected 000", {a0, a1, a2}); end
    vecCnt++; if (pulseCnt - p0 !== 1) begin errCnt++; $display("[TB] FAIL rmr_w_pulses: got %0d expected 1", pulseCnt - p0); end
    vecCnt++; if ({lastAddr, lastData} !== 16'h015A) begin errCnt++; $display("[TB] FAIL rmr_w_addr_data: got %h expected 015a", {lastAddr, lastData}); end
    vecCnt++; if (regs_o !== expRegs) begin errCnt++; $display("[TB] FAIL rmr_w_regs: got %h expected %h", regs_o, expRegs); end
  endtask

  initial begin
    #(4*Q);
    rst_n = 1'b1;
    #(2*Q);
    test_reset();
    test_write3();
    test_pointer_read();
    test_wrong_id();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    vecCnt++; if (highCycles !== pulseCnt) begin errCnt++; $display("[TB] FAIL pulse_width_total: got %0d high cycles expected %0d", highCycles, pulseCnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/sccb_slave_regfile.md
# sccb_slave_regfile

Synthesizable SCCB slave (responder) holding an 8-bit register file, for the far end of the bus driven by the SCCB master controller. It oversamples `sio_c`/`sio_d` with the system clock and decodes start, stop, ID, sub-address and data phases. It executes 3-phase writes, 2-phase writes (pointer set) and 2-phase reads, acknowledging by pulling `sio_d` low. It is used as an on-chip camera-register model and as the loopback target for controller bring-up.

## Interface

- `SLV_DVC_ADDR`, 7'h21, 7-bit device ID this slave answers to (bus ID byte = {ID, R/W}).
- `REG_NUM`, 16, number of 8-bit registers (1..256).
- `DATA_W`, 8, register width; fixed at 8.
- `clk`  input  1  system clock; must be ≥ 16× SCCB clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `sio_c`  input  1  SCCB clock from master.
- `sio_d`  inout  1  SCCB data; open-drain: driven `1'b0` or `1'bz`, never `1'b1`.
- `reg_wr_en_o`  output  1  one-cycle pulse when a bus write updates a register.
- `reg_wr_addr_o`  output  8  sub-address of that write.
- `reg_wr_data_o`  output  8  data of that write.
- `regs_o`  output  REG_NUM*8  flattened register file; reg k at bits [8k+7:8k].
- `busy_o`  output  1  high from detected start until detected stop.

## Operation

- Input path: `sio_c` and `sio_d` each pass a 2-FF synchronizer, then one history flop for edge detection. All decode uses synced values.
- Start: synced `sio_d` falls while synced `sio_c` is high. Stop: `sio_d` rises while `sio_c` is high. Both are valid in any state.
  - Start, including repeated start, enters ID with bit counter = 0.
  - Stop enters IDLE.
- Bits are sampled on synced `sio_c` rising edges, MSB first. The slave changes its `sio_d` drive only on synced `sio_c` falling edges.
- Each phase is 9 bits, counted 0..8.
- States and transitions:
  - IDLE: wait for start.
  - ID: shift 8 bits.
    - ID ≠ SLV_DVC_ADDR: go to IGNORE; no ACK.
    - Match with R/W=0: ID_ACK, then SUBADR.
    - Match with R/W=1: ID_ACK, then RDATA.
  - SUBADR: shift 8 bits, SUBADR_ACK, latch pointer = sub-address, then WDATA.
  - WDATA: shift 8 bits, WDATA_ACK, commit the write, then IGNORE. Further bytes are not acknowledged and not written.
  - RDATA: drive the byte at `pointer`, then RDATA_NA. During RDATA_NA `sio_d` is released and the master's bit is ignored; then IGNORE.
  - IGNORE: `sio_d` released; wait for start or stop.
- ACK drive: in ID_ACK, SUBADR_ACK and WDATA_ACK, hold `sio_d` low from the falling edge after bit 7 to the falling edge after bit 8.
- Read drive:
  - Bit 7 of the byte is presented on the falling edge ending ID_ACK.
  - Each following falling edge presents the next bit.
  - A data 1 means release.
- Pointer:
  - Persists across transactions and is not incremented by reads or writes.
  - A 2-phase write (stop after SUBADR_ACK) only sets the pointer.
- Out-of-range sub-address (≥ REG_NUM):
  - The sub-address phase is still ACKed and the pointer is stored.
  - A write to it is ACKed, but no register changes and there is no `reg_wr_en_o` pulse.
  - A read from it returns 8'h00.
- Commit: register update and `reg_wr_en_o`/`reg_wr_addr_o`/`reg_wr_data_o` occur together, registered, on the clock after the bit-7 rising edge of WDATA is detected.

## Timing

- Reset values:
  - `regs_o` = 0, pointer = 0, state IDLE.
  - `reg_wr_en_o` = 0, `reg_wr_addr_o` = 0, `reg_wr_data_o` = 0, `busy_o` = 0.
  - `sio_d` released (z).
- Reset mid-transaction releases `sio_d` asynchronously; the transaction is lost.
- Pin-to-decode latency: 3 clk (2 sync + 1 edge).
- Drive change: within 4 clk of the `sio_c` pin falling edge.
- Write visibility: `regs_o` is updated in the same cycle that `reg_wr_en_o` is high, about 4 clk after the pin rising edge of the last data bit.
- `reg_wr_en_o` is exactly 1 cycle wide, at most once per transaction.
- `busy_o` rises 1 cycle after start detection and falls 1 cycle after stop detection.
- Start and stop take priority over bit sampling in the same cycle.
- `sio_c` high while `sio_d` toggles is never treated as a data bit.

## Test plan

- 3-phase write: bytes 0x42, 0x05, 0xA5, then stop.
  - `sio_d` low during all three 9th bits.
  - Single pulse with addr 0x05, data 0xA5.
  - `regs_o[47:40]` = 0xA5.
- Pointer set then read: 2-phase write 0x42, 0x05, stop; then 0x43 and 8 clocks, with master NA = 1 and stop.
  - Slave drives 1,0,1,0,0,1,0,1 (0xA5).
  - `sio_d` released at the NA bit; no write pulse.
- Wrong ID: 0x60, 0x05, 0x11.
  - `sio_d` never driven low.
  - No pulse; `regs_o` unchanged; `busy_o` high until stop.
- Out of range, with REG_NUM=16:
  - Write 0x42, 0x20, 0x77: all three phases ACKed, no pulse, regs unchanged.
  - Then read 0x43: returns 0x00.
- Repeated start after the SUBADR ACK, then 0x43 read.
  - Returns the register at the new pointer.
  - Extra 4th write byte after WDATA is not ACKed and does not change regs.
- Reset asserted during RDATA while a 0 is being driven.
  - `sio_d` goes z immediately.
  - All outputs and regs return to 0; after reset a 3-phase write works normally.
